// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, tables and round helpers.
// Byte 0 of a 128-bit block sits in bits [127:120], column-major.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry n is the constant for round n; unused slots are zero.
  localparam logic [0:15][7:0] RCON =
    128'h0001020408102040801b360000000000;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
    return o;
  endfunction

  // Row r of column c takes the byte from column (c+r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-32*c-8*r -: 8] = s[127-32*((c+r)%4)-8*r -: 8];
    return o;
  endfunction

  function automatic logic [127:0] key_expansion(
    input logic [127:0] k,
    input logic [3:0]   rnd
  );
    logic [31:0]  t;
    logic [127:0] o;
    t = {SBOX[k[23:16]], SBOX[k[15:8]],
         SBOX[k[7:0]],   SBOX[k[31:24]]}
        ^ {RCON[rnd], 24'h0};
    o[127:96] = k[127:96] ^ t;
    o[95:64]  = k[95:64]  ^ o[127:96];
    o[63:32]  = k[63:32]  ^ o[95:64];
    o[31:0]   = k[31:0]   ^ o[63:32];
    return o;
  endfunction

  function automatic logic [127:0] add_round_key(
    input logic [127:0] s,
    input logic [127:0] k
  );
    return s ^ k;
  endfunction

endpackage

// File: rtl/aes_round_iter_if.sv
// aes_round_iter_if: input pair handshake, round-9 output handshake
// and status between the round engine and its neighbours.
interface aes_round_iter_if #(
  parameter int ROUND_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [127:0]       plaintext;
  logic [127:0]       key;
  logic               out_valid;
  logic               out_ready;
  logic [127:0]       state_out;
  logic [127:0]       key_out;
  logic [ROUND_W-1:0] round_out;
  logic               busy;

  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, state_out, key_out,
    input  round_out, busy
  );

  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, state_out, key_out,
    output round_out, busy
  );
endinterface

// File: rtl/mix_columns.sv
// mix_columns: AES MixColumns on all four columns, each column
// multiplied by the circulant {02,03,01,01} matrix using xtime.
module mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] w_a0, w_a1, w_a2, w_a3;

    assign w_a0 = i_state[127-32*c -: 8];
    assign w_a1 = i_state[119-32*c -: 8];
    assign w_a2 = i_state[111-32*c -: 8];
    assign w_a3 = i_state[103-32*c -: 8];

    assign o_state[127-32*c -: 8] =
      xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
    assign o_state[119-32*c -: 8] =
      w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
    assign o_state[111-32*c -: 8] =
      w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
    assign o_state[103-32*c -: 8] =
      xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
  end

endmodule

// File: rtl/aes_round_iter.sv
// aes_round_iter: iterative AES-128 rounds 1..9, one per clock,
// handing the round-9 state and key to a combinational final stage.
module aes_round_iter #(
  parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS,
  parameter int ROUND_W    = 4
) (
  input logic             clk,
  input logic             rst,
  aes_round_iter_if.slave bus
);
  import aes_pkg::*;

  if (NUM_ROUNDS != 10 || ROUND_W != 4) begin : g_bad_cfg
    $error("aes_round_iter supports AES-128 only");
  end

  localparam logic [ROUND_W-1:0] LAST  = ROUND_W'(NUM_ROUNDS - 1);
  localparam logic [ROUND_W-1:0] FINAL = ROUND_W'(NUM_ROUNDS);
  localparam logic [ROUND_W-1:0] ONE   = ROUND_W'(1);

  state_e             r_fsm;
  logic [127:0]       r_state;
  logic [127:0]       r_rkey;
  logic [ROUND_W-1:0] r_round;

  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [127:0] w_nk;

  assign w_sr = shift_rows(sub_bytes(r_state));
  assign w_nk = key_expansion(r_rkey, r_round);

  mix_columns u_mix (
    .i_state (w_sr),
    .o_state (w_mc)
  );

  // Accept a pair, iterate rounds, then hold until the final stage takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm   <= IDLE;
      r_state <= '0;
      r_rkey  <= '0;
      r_round <= '0;
    end else begin
      unique case (r_fsm)
        IDLE: begin
          if (bus.in_valid) begin
            r_state <= add_round_key(bus.plaintext, bus.key);
            r_rkey  <= bus.key;
            r_round <= ONE;
            r_fsm   <= RUN;
          end
        end
        RUN: begin
          r_state <= add_round_key(w_mc, w_nk);
          r_rkey  <= w_nk;
          if (r_round == LAST) begin
            r_round <= FINAL;
            r_fsm   <= DONE;
          end else begin
            r_round <= r_round + ONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_round <= '0;
            r_fsm   <= IDLE;
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_fsm == IDLE) && !rst;
  assign bus.out_valid = (r_fsm == DONE);
  assign bus.busy      = (r_fsm != IDLE);
  assign bus.state_out = r_state;
  assign bus.key_out   = r_rkey;
  assign bus.round_out = r_round;

endmodule

// File: tb/tb_aes_round_iter.sv
// tb_aes_round_iter: FIPS-197 and randomized checks of the iterative
// AES-128 round engine against a byte-level reference model.
module tb_aes_round_iter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] sb [256];

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] S1 = 128'heb40f21e592e38848ba113e71bc342d2;
  localparam logic [127:0] R1 = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_round_iter_if #(.ROUND_W(4)) bus ();

  aes_round_iter #(.NUM_ROUNDS(10), .ROUND_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (GF(2^8) arithmetic) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
            ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] m_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sb[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] m_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-32*c-8*r -: 8] = s[127-32*((c+r)%4)-8*r -: 8];
    return o;
  endfunction

  function automatic logic [127:0] m_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-32*c-8*r -: 8];
      for (int r = 0; r < 4; r++)
        o[127-32*c-8*r -: 8] = gmul(8'h02, a[r])
          ^ gmul(8'h03, a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return o;
  endfunction

  function automatic logic [127:0] m_nextkey(input logic [127:0] k,
                                             input logic [7:0]   rc);
    logic [31:0] w [8];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    t = {w[3][23:0], w[3][31:24]};
    t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]}
        ^ {rc, 24'h0};
    for (int i = 4; i < 8; i++) begin
      w[i] = w[i-4] ^ t;
      t    = w[i];
    end
    return {w[4], w[5], w[6], w[7]};
  endfunction

  task automatic model(input  logic [127:0] pt, input logic [127:0] k,
                       output logic [127:0] s9, output logic [127:0] k9,
                       output logic [127:0] ct);
    logic [127:0] s;
    logic [127:0] rk;
    logic [7:0]   rc;
    s  = pt ^ k;
    rk = k;
    rc = 8'h01;
    for (int r = 1; r <= 9; r++) begin
      rk = m_nextkey(rk, rc);
      rc = gmul(rc, 8'h02);
      s  = m_mix(m_shift(m_sub(s))) ^ rk;
    end
    s9 = s;
    k9 = rk;
    ct = m_shift(m_sub(s)) ^ m_nextkey(rk, rc);
  endtask

  // Combinational final-round stage fed by the DUT outputs.
  function automatic logic [127:0] final_round(input logic [127:0] s,
                                               input logic [127:0] k9);
    return m_shift(m_sub(s)) ^ m_nextkey(k9, 8'h36);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic accept(input logic [127:0] pt, input logic [127:0] k);
    bus.plaintext = pt;
    bus.key       = k;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0; #1;
    rst = 1'b1; #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b exp 0", bus.in_ready);
    end
    checks++;
    if ({bus.out_valid, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: got %b%b exp 00",
               bus.out_valid, bus.busy);
    end
    checks++;
    if (bus.state_out !== '0 || bus.key_out !== '0
        || bus.round_out !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h exp zeros",
               bus.state_out, bus.key_out, bus.round_out);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready got %b exp 1", bus.in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fips_b();
    int n;
    bus.out_ready = 1'b1;
    accept(P1, K1);
    wait_out(n);
    checks++;
    if (n != 9) begin
      errors++;
      $display("FAIL b_latency: got %0d exp 9", n);
    end
    checks++;
    if (bus.state_out !== S1) begin
      errors++;
      $display("FAIL b_state: got %h exp %h", bus.state_out, S1);
    end
    checks++;
    if (bus.key_out !== R1) begin
      errors++;
      $display("FAIL b_key: got %h exp %h", bus.key_out, R1);
    end
    checks++;
    if (bus.round_out !== 4'd10) begin
      errors++;
      $display("FAIL b_round: got %0d exp 10", bus.round_out);
    end
    checks++;
    if (final_round(bus.state_out, bus.key_out) !== C1) begin
      errors++;
      $display("FAIL b_cipher: got %h exp %h",
               final_round(bus.state_out, bus.key_out), C1);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b_release: out_valid %b in_ready %b exp 0 1",
               bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_fips_c();
    int n;
    logic [127:0] s9, k9, ct;
    model(P2, K2, s9, k9, ct);
    bus.out_ready = 1'b1;
    accept(P2, K2);
    wait_out(n);
    checks++;
    if (n != 9 || bus.state_out !== s9 || bus.key_out !== k9) begin
      errors++;
      $display("FAIL c_round9: lat %0d state %h key %h exp 9 %h %h",
               n, bus.state_out, bus.key_out, s9, k9);
    end
    checks++;
    if (final_round(bus.state_out, bus.key_out) !== C2) begin
      errors++;
      $display("FAIL c_cipher: got %h exp %h",
               final_round(bus.state_out, bus.key_out), C2);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    logic [127:0] pt, k, s9, k9, ct;
    pt = {$urandom, $urandom, $urandom, $urandom};
    k  = {$urandom, $urandom, $urandom, $urandom};
    model(pt, k, s9, k9, ct);
    bus.out_ready = 1'b0;
    accept(pt, k);
    wait_out(n);
    checks++;
    if (n != 9) begin
      errors++;
      $display("FAIL bp_latency: got %0d exp 9", n);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0
          || bus.state_out !== s9 || bus.key_out !== k9
          || bus.round_out !== 4'd10) begin
        errors++;
        $display("FAIL bp_hold[%0d]: v%b r%b %h %h %0d exp 1 0 %h %h 10",
                 i, bus.out_valid, bus.in_ready, bus.state_out,
                 bus.key_out, bus.round_out, s9, k9);
      end
    end
    checks++;
    if (final_round(bus.state_out, bus.key_out) !== ct) begin
      errors++;
      $display("FAIL bp_cipher: got %h exp %h",
               final_round(bus.state_out, bus.key_out), ct);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0
        || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: v%b b%b r%b exp 0 0 1",
               bus.out_valid, bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_ignore_busy();
    int n;
    int hold_bad;
    bus.out_ready = 1'b0;
    accept(P1, K1);
    bus.in_valid  = 1'b1;
    bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
    bus.key       = {$urandom, $urandom, $urandom, $urandom};
    hold_bad = 0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      if (bus.in_ready !== 1'b0) hold_bad++;
      @(posedge clk); #1;
      n++;
    end
    repeat (3) begin
      if (bus.in_ready !== 1'b0) hold_bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (n != 9 || hold_bad != 0) begin
      errors++;
      $display("FAIL ib_busy: lat %0d ready_hi %0d exp 9 0", n, hold_bad);
    end
    checks++;
    if (bus.state_out !== S1 || bus.key_out !== R1) begin
      errors++;
      $display("FAIL ib_result: got %h %h exp %h %h",
               bus.state_out, bus.key_out, S1, R1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ib_single: busy %b in_ready %b exp 0 1",
               bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_async_reset();
    int n;
    bus.out_ready = 1'b1;
    accept(P1, K1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    checks++;
    if (bus.round_out !== 4'd5 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL ar_round5: round %0d busy %b exp 5 1",
               bus.round_out, bus.busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0
        || bus.busy !== 1'b0 || bus.state_out !== '0
        || bus.key_out !== '0 || bus.round_out !== '0) begin
      errors++;
      $display("FAIL ar_immediate: r%b v%b b%b %h %h %0d exp all zero",
               bus.in_ready, bus.out_valid, bus.busy,
               bus.state_out, bus.key_out, bus.round_out);
    end
    @(posedge clk); #1;
    rst = 1'b0; #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ar_release: in_ready %b busy %b exp 1 0",
               bus.in_ready, bus.busy);
    end
    accept(P1, K1);
    wait_out(n);
    checks++;
    if (n != 9 || bus.state_out !== S1
        || final_round(bus.state_out, bus.key_out) !== C1) begin
      errors++;
      $display("FAIL ar_rerun: lat %0d state %h exp 9 %h",
               n, bus.state_out, S1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    logic [127:0] s9, k9, ct;
    model(P2, K2, s9, k9, ct);
    bus.out_ready = 1'b1;
    bus.plaintext = P1;
    bus.key       = K1;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.plaintext = P2;
    bus.key       = K2;
    wait_out(n1);
    checks++;
    if (n1 != 9 || bus.state_out !== S1 || bus.key_out !== R1) begin
      errors++;
      $display("FAIL bb_first: lat %0d state %h exp 9 %h",
               n1, bus.state_out, S1);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bb_gap: busy %b in_ready %b exp 0 1",
               bus.busy, bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL bb_second_accept: busy %b exp 1", bus.busy);
    end
    wait_out(n2);
    checks++;
    if (n2 != 9 || bus.state_out !== s9 || bus.key_out !== k9) begin
      errors++;
      $display("FAIL bb_second: lat %0d state %h exp 9 %h",
               n2, bus.state_out, s9);
    end
    checks++;
    if (final_round(bus.state_out, bus.key_out) !== C2) begin
      errors++;
      $display("FAIL bb_cipher: got %h exp %h",
               final_round(bus.state_out, bus.key_out), C2);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    int n;
    int d;
    logic [127:0] pt, k, s9, k9, ct;
    for (int t = 0; t < 8; t++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      model(pt, k, s9, k9, ct);
      d = $urandom_range(0, 3);
      bus.out_ready = 1'b0;
      accept(pt, k);
      wait_out(n);
      repeat (d) begin
        @(posedge clk); #1;
      end
      checks++;
      if (n != 9 || bus.state_out !== s9 || bus.key_out !== k9
          || bus.round_out !== 4'd10) begin
        errors++;
        $display("FAIL rnd[%0d]: lat %0d %h %h %0d exp 9 %h %h 10",
                 t, n, bus.state_out, bus.key_out, bus.round_out,
                 s9, k9);
      end
      checks++;
      if (final_round(bus.state_out, bus.key_out) !== ct) begin
        errors++;
        $display("FAIL rnd_cipher[%0d]: got %h exp %h", t,
                 final_round(bus.state_out, bus.key_out), ct);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.plaintext = '0;
    bus.key       = '0;
    build_sbox();
    test_reset();
    test_fips_b();
    test_fips_c();
    test_backpressure();
    test_ignore_busy();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
